// File: rtl/decoder_scan_sequencer_pkg.sv
// Package for the decoder scan sequencer.
// Holds the FSM state type, the default select/dwell widths and the
// dwell clamp helper (a programmed dwell of 0 behaves as 1).
package decoder_scan_pkg;

    typedef enum logic {
        IDLE,
        DWELL
    } scan_state_e;

    localparam int unsigned DEF_SEL_W   = 4;
    localparam int unsigned DEF_NUM_CH  = 2 ** DEF_SEL_W;
    localparam int unsigned DEF_DWELL_W = 8;

    // Effective dwell D = max(dwell, 1)
    function automatic int unsigned clamp_dwell(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan controller (master) and the
// decoder scan sequencer (slave).
//   start, stop, continuous, chan_mask, dwell : master -> sequencer
//   sel, sel_valid, busy, chan_step, done     : sequencer -> master
interface decoder_scan_sequencer_if #(
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned DWELL_W = 8
);
    localparam int unsigned NUM_CH = 2 ** SEL_W;

    logic               start;
    logic               stop;
    logic               continuous;
    logic [NUM_CH-1:0]  chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               busy;
    logic               chan_step;
    logic               done;

    modport master (
        output start, stop, continuous, chan_mask, dwell,
        input  sel, sel_valid, busy, chan_step, done
    );

    modport slave (
        input  start, stop, continuous, chan_mask, dwell,
        output sel, sel_valid, busy, chan_step, done
    );
endinterface

// File: rtl/decoder_scan_sequencer_next_finder.sv
// Combinational channel search for the scan sequencer.
//   mask        : enabled channels
//   sel         : current channel
//   next_idx    : lowest enabled index strictly above sel (valid if next_found)
//   first_idx   : lowest enabled index overall (valid if first_found)
module scan_next_finder #(
    parameter int unsigned SEL_W = 4
) (
    input  logic [2**SEL_W-1:0] mask,
    input  logic [SEL_W-1:0]    sel,
    output logic [SEL_W-1:0]    next_idx,
    output logic                next_found,
    output logic [SEL_W-1:0]    first_idx,
    output logic                first_found
);
    localparam int unsigned NUM_CH = 2 ** SEL_W;

    always_comb begin
        next_idx    = '0;
        next_found  = 1'b0;
        first_idx   = '0;
        first_found = 1'b0;
        // Ascending scan; the found flags freeze the lowest match.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (mask[i] && !first_found) begin
                first_idx   = SEL_W'(i);
                first_found = 1'b1;
            end
            if (mask[i] && !next_found && (i > 32'(sel))) begin
                next_idx   = SEL_W'(i);
                next_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/decoder_scan_sequencer.sv
// Decoder scan sequencer: walks the enabled channels of a 16-bit mask,
// lowest index first, holding each for D = max(dwell,1) cycles, and
// presents the select to the downstream 4-to-16 decoder.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of decoder_scan_sequencer_if (control in, sel/status out)
module decoder_scan_sequencer
    import decoder_scan_pkg::*;
#(
    parameter int unsigned SEL_W   = DEF_SEL_W,
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    decoder_scan_sequencer_if.slave   bus
);
    localparam int unsigned NUM_CH = 2 ** SEL_W;

    scan_state_e        state;
    logic [NUM_CH-1:0]  mask_q;
    logic               cont_q;
    logic [DWELL_W-1:0] reload_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic               valid_q;
    logic               busy_q;
    logic               step_q;
    logic               done_q;

    logic [NUM_CH-1:0]  search_mask;
    logic [SEL_W-1:0]   next_idx;
    logic               next_found;
    logic [SEL_W-1:0]   first_idx;
    logic               first_found;
    logic [DWELL_W-1:0] start_reload;

    // One finder serves both phases: in IDLE it searches the live mask
    // (first channel and empty-mask test), while scanning it searches
    // the latched mask so mid-scan mask changes have no effect.
    assign search_mask  = (state == IDLE) ? bus.chan_mask : mask_q;
    assign start_reload = DWELL_W'(clamp_dwell(32'(bus.dwell)) - 1);

    scan_next_finder #(
        .SEL_W (SEL_W)
    ) u_finder (
        .mask        (search_mask),
        .sel         (sel_q),
        .next_idx    (next_idx),
        .next_found  (next_found),
        .first_idx   (first_idx),
        .first_found (first_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            reload_q <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop && first_found) begin
                        mask_q   <= bus.chan_mask;
                        cont_q   <= bus.continuous;
                        reload_q <= start_reload;
                        cnt_q    <= start_reload;
                        sel_q    <= first_idx;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        step_q   <= 1'b1;
                        state    <= DWELL;
                    end
                end
                DWELL: begin
                    if (bus.stop) begin
                        state   <= IDLE;
                        sel_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end else if (next_found) begin
                        sel_q  <= next_idx;
                        cnt_q  <= reload_q;
                        step_q <= 1'b1;
                    end else if (cont_q) begin
                        sel_q  <= first_idx;
                        cnt_q  <= reload_q;
                        step_q <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        sel_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.chan_step = step_q;
    assign bus.done      = done_q;
endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream stage of the 4-to-16 decoder: generates the 4-bit select that feeds decoder_4to16 input_bits.
- Steps through the channels enabled in a 16-bit mask, lowest index first.
- Holds each channel for a programmable dwell time.
- Runs one pass or loops continuously, with start/stop control and status pulses.

Parameters:
- SEL_W, 4, select width; channel count is 2**SEL_W (16).
- DWELL_W, 8, width of the dwell-time input and the internal dwell counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset.
- start  in  1  level-sampled request to begin a scan.
- stop  in  1  abort the current scan.
- continuous  in  1  1 = wrap after the last enabled channel; 0 = single pass.
- chan_mask  in  2**SEL_W  channel enables; bit i enables select value i.
- dwell  in  DWELL_W  cycles per channel; 0 is treated as 1.
- sel  out  SEL_W  channel select to the decoder.
- sel_valid  out  1  sel is meaningful; decoder output is qualified by this.
- busy  out  1  scan in progress.
- chan_step  out  1  one-cycle pulse on every channel load, including the first and wrap-to-same-channel.
- done  out  1  one-cycle pulse when a single pass completes normally.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - Reset values: sel=0, sel_valid=0, busy=0, chan_step=0, done=0, state=IDLE.
  - All outputs are registered.
- States: IDLE, DWELL.
- IDLE, start=1, stop=0, chan_mask!=0:
  - Latch chan_mask, continuous and D=max(dwell,1).
  - Next edge: sel = lowest set bit index, sel_valid=1, busy=1, chan_step=1, dwell counter loaded with D-1, state goes to DWELL.
  - sel_valid is high in the cycle after start is sampled (one-cycle latency).
- IDLE, start=1 with chan_mask==0: ignored; no outputs change, no done.
- IDLE, start and stop both high: stop wins; start is ignored.
- DWELL, counter>0: decrement; sel is held.
- DWELL, counter==0: move to the next set bit above sel in the latched mask.
  - If one exists: sel = that index, counter reloaded to D-1, chan_step=1.
  - If none and latched continuous=1: sel = lowest set bit, reload counter, chan_step=1.
  - If none and continuous=0: go to IDLE; sel=0, sel_valid=0, busy=0, done=1 for one cycle.
- Each enabled channel is therefore held for exactly D cycles. Disabled channels never appear on sel.
- stop=1 in DWELL: next edge goes to IDLE with sel=0, sel_valid=0, busy=0; done is not pulsed. stop has priority over the counter==0 transition in the same cycle.
- start while busy: ignored.
- Changes to chan_mask, dwell or continuous mid-scan: no effect until the next start.
- Single-bit mask with continuous=1: sel stays constant, and chan_step pulses every D cycles.
- Reset asserted mid-scan: immediate return to the reset values; no done pulse.
- Wrap search uses unsigned index arithmetic only. Index 2**SEL_W-1 has no higher bit, so it always triggers the wrap or finish path.

Decomposition:
- Package decoder_scan_pkg:
  - State enum typedef (IDLE, DWELL).
  - SEL_W and NUM_CH=2**SEL_W default constants.
  - Dwell-clamp helper function, max(dwell,1).
- Sub-module scan_next_finder (combinational):
  - Inputs: latched mask, current sel.
  - Outputs: next_idx, next_found, first_idx, first_found.
  - Lowest-index priority encoding in both cases.
- Top level holds the FSM, the counter and the output registers. Its sel output drives decoder_4to16 input_bits directly.

Test Plan:
- Reset, then start with mask=16'h0041, dwell=3, continuous=0:
  - sel=0 valid for 3 cycles, then sel=6 for 3 cycles.
  - Then done=1 for one cycle, and busy/sel_valid drop with sel=0.
  - chan_step pulses twice.
- mask=16'h8001, dwell=0, continuous=1:
  - sel alternates 0,15,0,15 every cycle, with chan_step high every cycle.
  - Assert stop: IDLE next edge, sel_valid=0, no done.
- start with mask=16'h0000: busy, sel_valid, chan_step and done all remain 0 for 10 cycles.
- mask=16'h0010, dwell=5, continuous=1: sel=4 constant, with chan_step pulsing every 5 cycles.
- Scan with mask=16'h00FF, dwell=2:
  - Mid-scan, pulse start and change mask to 16'hFF00; the sequence continues 0..7 unchanged.
  - Then assert rst_n=0 mid-channel: all outputs are 0 asynchronously, and no done is seen.
- Drive sel into decoder_4to16 with mask=16'hFFFF, dwell=1, continuous=0: the decoder output walks one-hot 16'h0001 through 16'h8000, exactly once each, then done.
